// File: rtl/aes_key_expand.sv
// AES key schedule expander: writes one schedule word per clock into a registered KExp array.
// Optional macro AES_KEXP_ZEROIZE_EN clears the non-key words whenever a Start is accepted.
package aes_const;
   parameter int Nb = 4;
   parameter int Nk = 4;
   parameter int Nr = 10;
endpackage

module aes_key_expand #(
   parameter int Nb = aes_const::Nb,
   parameter int Nk = aes_const::Nk,
   parameter int Nr = aes_const::Nr
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  SBox   [0:255],
   input  logic [31:0] Key_in [0:Nk-1],
   input  logic        Start,
   output logic        Ready,
   output logic        Valid,
   output logic [31:0] KExp   [0:Nb*(Nr+1)-1]
);
   localparam int NW = Nb*(Nr+1);
   localparam int IW = $clog2(NW);

   typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

   state_t        r_state;
   logic [IW-1:0] r_idx;
   logic [2:0]    r_col;      // tracks i mod Nk without a divider
   logic [7:0]    r_rcon;
   logic          r_ready;
   logic          r_valid;
   logic [31:0]   r_kexp [0:NW-1];

   logic [31:0] w_prev;
   logic [31:0] w_back;
   logic [31:0] w_sub_in;
   logic [31:0] w_sub;
   logic [31:0] w_temp;
   logic [31:0] w_word;
   logic [7:0]  w_rcon_next;
   logic        w_rot_step;
   logic        w_sub_step;

   assign w_prev      = r_kexp[r_idx - IW'(1)];
   assign w_back      = r_kexp[r_idx - IW'(Nk)];
   assign w_rot_step  = (r_col == 3'd0);
   assign w_sub_step  = (Nk > 6) && (r_col == 3'd4);
   assign w_sub_in    = w_rot_step ? {w_prev[23:0], w_prev[31:24]} : w_prev;
   assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

   for (genvar gi = 0; gi < 4; gi++) begin : g_sub
      assign w_sub[8*gi +: 8] = SBox[w_sub_in[8*gi +: 8]];
   end

   always_comb begin
      w_temp = w_prev;
      if (w_rot_step)
         w_temp = w_sub ^ {r_rcon, 24'h0};
      else if (w_sub_step)
         w_temp = w_sub;
   end

   assign w_word = w_back ^ w_temp;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
         r_ready <= 1'b1;
         r_valid <= 1'b0;
         r_idx   <= IW'(Nk);
         r_col   <= 3'd0;
         r_rcon  <= 8'h01;
         for (int k = 0; k < NW; k++)
            r_kexp[k] <= 32'h0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (Start) begin
                  for (int k = 0; k < Nk; k++)
                     r_kexp[k] <= Key_in[k];
`ifdef AES_KEXP_ZEROIZE_EN
                  for (int k = Nk; k < NW; k++)
                     r_kexp[k] <= 32'h0;
`endif
                  r_idx   <= IW'(Nk);
                  r_col   <= 3'd0;
                  r_rcon  <= 8'h01;
                  r_valid <= 1'b0;
                  r_ready <= 1'b0;
                  r_state <= EXPAND;
               end
            end
            EXPAND: begin
               r_kexp[r_idx] <= w_word;
               if (w_rot_step)
                  r_rcon <= w_rcon_next;
               // Index stops at the last word; Valid rises with that final write.
               if (r_idx == IW'(NW-1)) begin
                  r_valid <= 1'b1;
                  r_ready <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_idx <= r_idx + IW'(1);
                  r_col <= (r_col == 3'(Nk-1)) ? 3'd0 : r_col + 3'd1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_ready <= 1'b1;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   for (genvar gi = 0; gi < NW; gi++) begin : g_out
      assign KExp[gi] = r_kexp[gi];
   end

   assign Ready = r_ready;
   assign Valid = r_valid;
endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: AES-128/192/256 instances share clock, reset, Start and S-box,
// and are checked word by word against a FIPS-197 style reference model.
module tb_aes_key_expand;
   logic        clk;
   logic        rst;
   logic        Start;
   logic [7:0]  sbox [0:255];
   logic [31:0] key4 [0:3];
   logic [31:0] key6 [0:5];
   logic [31:0] key8 [0:7];
   logic [31:0] kexp4 [0:43];
   logic [31:0] kexp6 [0:51];
   logic [31:0] kexp8 [0:59];
   logic        rdy4, rdy6, rdy8;
   logic        v4, v6, v8;

   logic [31:0] keys [3][8];
   logic [31:0] mdl  [3][60];
   logic [31:0] held [3][60];
   logic [31:0] last_c1;
   int          n_checks = 0;
   int          n_fail   = 0;

   aes_key_expand #(.Nk(4), .Nr(10)) u_k128 (
      .clk(clk), .rst(rst), .SBox(sbox), .Key_in(key4), .Start(Start),
      .Ready(rdy4), .Valid(v4), .KExp(kexp4));
   aes_key_expand #(.Nk(6), .Nr(12)) u_k192 (
      .clk(clk), .rst(rst), .SBox(sbox), .Key_in(key6), .Start(Start),
      .Ready(rdy6), .Valid(v6), .KExp(kexp6));
   aes_key_expand #(.Nk(8), .Nr(14)) u_k256 (
      .clk(clk), .rst(rst), .SBox(sbox), .Key_in(key8), .Start(Start),
      .Ready(rdy8), .Valid(v8), .KExp(kexp8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int nk_of(input int d);
      return 4 + 2*d;
   endfunction

   function automatic int nw_of(input int d);
      return 4 * (nk_of(d) + 7);
   endfunction

   function automatic logic dut_valid(input int d);
      case (d)
         0: return v4;
         1: return v6;
         default: return v8;
      endcase
   endfunction

   function automatic logic dut_ready(input int d);
      case (d)
         0: return rdy4;
         1: return rdy6;
         default: return rdy8;
      endcase
   endfunction

   function automatic logic [31:0] dut_word(input int d, input int k);
      case (d)
         0: return kexp4[k];
         1: return kexp6[k];
         default: return kexp8[k];
      endcase
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int n = 0; n < 8; n++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   // S-box from its definition: GF(2^8) inverse followed by the affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
   endfunction

   function automatic logic [7:0] rcon_of(input int j);
      logic [7:0] r;
      r = 8'h01;
      for (int n = 1; n < j; n++) r = gmul(r, 8'h02);
      return r;
   endfunction

   task automatic model(input int d);
      int nk, nw;
      logic [31:0] t;
      nk = nk_of(d);
      nw = nw_of(d);
      for (int i = 0; i < nk; i++) mdl[d][i] = keys[d][i];
      for (int i = nk; i < nw; i++) begin
         t = mdl[d][i-1];
         if (i % nk == 0)
            t = subw({t[23:0], t[31:24]}) ^ {rcon_of(i / nk), 24'h0};
         else if (nk > 6 && i % nk == 4)
            t = subw(t);
         mdl[d][i] = mdl[d][i-nk] ^ t;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_keys();
      for (int k = 0; k < 4; k++) key4[k] = keys[0][k];
      for (int k = 0; k < 6; k++) key6[k] = keys[1][k];
      for (int k = 0; k < 8; k++) key8[k] = keys[2][k];
   endtask

   task automatic random_keys();
      for (int d = 0; d < 3; d++)
         for (int k = 0; k < 8; k++) keys[d][k] = $urandom;
   endtask

   task automatic check_reset(input string tag);
      int nz;
      for (int d = 0; d < 3; d++) begin
         nz = 0;
         for (int k = 0; k < nw_of(d); k++)
            if (dut_word(d, k) !== 32'h0) nz++;
         check($sformatf("%s valid nk%0d", tag, nk_of(d)), 32'(dut_valid(d)), 32'd0);
         check($sformatf("%s ready nk%0d", tag, nk_of(d)), 32'(dut_ready(d)), 32'd1);
         check($sformatf("%s nonzero_words nk%0d", tag, nk_of(d)), nz, 32'd0);
      end
   endtask

   // One Start pulse, then every cycle each instance's Valid, Ready and full KExp are compared
   // with the words the model says are written so far (older words keep their prior value).
   task automatic run_expand(input string tag, input int repulse_at, input int rst_at);
      int nk, nw, n_lat;
      int bad [3];
      int first_v [3];
      logic [31:0] exp_w;
      for (int d = 0; d < 3; d++) begin
         model(d);
         bad[d] = 0;
         first_v[d] = -1;
         nk = nk_of(d);
         nw = nw_of(d);
         for (int k = 0; k < nw; k++) begin
            if (k < nk) held[d][k] = keys[d][k];
`ifdef AES_KEXP_ZEROIZE_EN
            else held[d][k] = 32'h0;
`endif
         end
      end
      drive_keys();
      Start = 1'b1;
      tick();
      Start = 1'b0;
      for (int c = 0; c <= 52; c++) begin
         for (int d = 0; d < 3; d++) begin
            nk = nk_of(d);
            nw = nw_of(d);
            n_lat = nw - nk;
            if (c == 1 && d == 0) last_c1 = kexp4[43];
            if (dut_valid(d) === 1'b1 && first_v[d] < 0) first_v[d] = c;
            if (dut_valid(d) !== (c >= n_lat) || dut_ready(d) !== (c >= n_lat)) bad[d]++;
            for (int k = 0; k < nw; k++) begin
               exp_w = (k < nk + c) ? mdl[d][k] : held[d][k];
               if (dut_word(d, k) !== exp_w) bad[d]++;
            end
         end
         if (c == repulse_at) begin
            random_keys();
            drive_keys();
            Start = 1'b1;
         end else begin
            Start = 1'b0;
         end
         if (c == rst_at) rst = 1'b0;
         if (c < 52) tick();
         if (c == rst_at) begin
            rst = 1'b1;
            for (int d = 0; d < 3; d++)
               check($sformatf("%s pre_abort nk%0d", tag, nk_of(d)), bad[d], 32'd0);
            check_reset({tag, " abort"});
            for (int d = 0; d < 3; d++)
               for (int k = 0; k < 60; k++) held[d][k] = 32'h0;
            $display("run %s: expansion aborted by reset at cycle %0d", tag, c);
            return;
         end
      end
      Start = 1'b0;
      for (int d = 0; d < 3; d++) begin
         n_lat = nw_of(d) - nk_of(d);
         check($sformatf("%s latency nk%0d", tag, nk_of(d)), first_v[d], n_lat);
         check($sformatf("%s schedule nk%0d", tag, nk_of(d)), bad[d], 32'd0);
         for (int k = 0; k < 60; k++) held[d][k] = mdl[d][k];
      end
      $display("run %s: expanded nk4 w43=%h nk6 w51=%h nk8 w59=%h", tag, kexp4[43], kexp6[51], kexp8[59]);
   endtask

   initial begin
      rst = 1'b0;
      Start = 1'b1;
      random_keys();
      drive_keys();
      build_sbox();
      for (int d = 0; d < 3; d++)
         for (int k = 0; k < 60; k++) held[d][k] = 32'h0;
      tick();
      tick();
      check_reset("reset");
      rst = 1'b1;
      Start = 1'b0;
      tick();
      check_reset("idle");

      keys[0][0:3] = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c};
      keys[1][0:5] = '{32'h8e73b0f7, 32'hda0e6452, 32'hc810f32b, 32'h809079e5,
                       32'h62f8ead2, 32'h522c6b7b};
      keys[2] = '{32'h603deb10, 32'h15ca71be, 32'h2b73aef0, 32'h857d7781,
                  32'h1f352c07, 32'h3b6108d7, 32'h2d9810a3, 32'h0914dff4};
      run_expand("fips", -1, -1);
      check("fips128 w4",  kexp4[4],  32'ha0fafe17);
      check("fips128 w43", kexp4[43], 32'hb6630ca6);
      check("fips192 w6",  kexp6[6],  32'hfe0c91f7);
      check("fips192 w51", kexp6[51], 32'h01002202);
      check("fips256 w8",  kexp8[8],  32'h9ba35411);
      check("fips256 w59", kexp8[59], 32'h706c631e);

      random_keys();
      run_expand("restart", -1, -1);
`ifdef AES_KEXP_ZEROIZE_EN
      check("restart w43_during_expand", last_c1, 32'h0);
`else
      check("restart w43_during_expand", last_c1, 32'hb6630ca6);
`endif

      random_keys();
      run_expand("repulse", 10, -1);

      random_keys();
      run_expand("abort", -1, 20);

      random_keys();
      run_expand("after_abort", -1, -1);

      for (int r = 0; r < 3; r++) begin
         random_keys();
         run_expand($sformatf("random%0d", r), -1, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
